sm_regdump: RTL and testbench
=============================

SM_REGDUMP -- requirements
Module: sm_regdump

Interface
REQ-001 Parameter: FIRST_REG, 0, first register index dumped (5-bit value).
REQ-002 Parameter: LAST_REG, 31, last register index dumped; FIRST_REG <= LAST_REG SHALL hold (elaboration error otherwise).
REQ-003 Parameter: SYNC_BYTE, 8'hA5, header byte opening every dump frame.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: start  input  1  single-cycle request to begin one dump frame.
REQ-007 Port: regAddr  output  5  debug register address driven to the CPU debug port.
REQ-008 Port: regData  input  32  debug register data returned by the CPU (combinational from regAddr; index 0 returns PC).
REQ-009 Port: tx_data  output  8  outgoing byte.
REQ-010 Port: tx_valid  output  1  tx_data holds a byte to transfer.
REQ-011 Port: tx_ready  input  1  sink accepts byte; transfer occurs on a cycle with tx_valid & tx_ready.
REQ-012 Port: busy  output  1  frame in progress.
REQ-013 Port: done  output  1  one-cycle pulse when a frame completes.

Function
REQ-014 Frame format SHALL be: SYNC_BYTE, then per register index i from FIRST_REG to LAST_REG ascending: one byte {3'b000, i}, then regData sampled at i as 4 bytes, MSB first; total bytes = 1 + 5*(LAST_REG-FIRST_REG+1).
REQ-015 States SHALL be IDLE, HDR, CAP, ADDR, DATA (4 sub-beats via 2-bit byte counter).
REQ-016 IDLE: tx_valid=0, busy=0; start=1 -> HDR next cycle, index loaded with FIRST_REG.
REQ-017 HDR: tx_valid=1, tx_data=SYNC_BYTE; on transfer -> CAP.
REQ-018 CAP: exactly one cycle, tx_valid=0, regAddr=index, regData captured into a 32-bit shift register -> ADDR.
REQ-019 ADDR: tx_valid=1, tx_data={3'b000,index}; on transfer -> DATA, byte counter=0.
REQ-020 DATA: tx_valid=1, tx_data=shift register [31:24]; on transfer shift left 8 and increment counter; on transfer with counter=3: if index==LAST_REG -> IDLE with done=1 next cycle, else index+1 -> CAP.
REQ-021 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL remain stable; tx_valid SHALL never drop without a transfer except on rst.
REQ-022 regAddr SHALL equal the current index in all states; register values are sampled per register in CAP, not as an atomic snapshot (CPU keeps running).
REQ-023 start while busy=1 SHALL be ignored (no restart, no queueing); start in the done cycle (state already IDLE) SHALL begin a new frame.
REQ-024 busy SHALL be 1 in HDR, CAP, ADDR, DATA and 0 in IDLE.
REQ-025 With tx_ready held 1, start at cycle t SHALL give header transfer at t+1, and frame length 1 + 6*N cycles, N = register count; done asserts the cycle after the final transfer.
REQ-026 Index increment SHALL not wrap: LAST_REG=31 terminates at 31 without overflow to 0.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, tx_valid=0, tx_data=0, busy=0, done=0, index=FIRST_REG (regAddr=FIRST_REG), shift register=0, byte counter=0.
REQ-028 rst mid-frame SHALL abort the frame with no done pulse; a partial frame is discarded by the sink via SYNC_BYTE resynchronisation.
REQ-029 rst has priority over start in the same cycle.

Verification
REQ-030 Default params, tx_ready=1, regs r1..r31 = 32'h1000_0000+i, PC=32'h0000_0040, pulse start -> 161 bytes: A5, 00, 00 00 00 40, 01, 10 00 00 01, ... , 1F, 10 00 00 1F; done after cycle 1+6*32=193.
REQ-031 FIRST_REG=5, LAST_REG=5, r5=32'hDEADBEEF, tx_ready toggling 1/0 each cycle -> bytes A5 05 DE AD BE EF, data stable during every ready=0 cycle, single done pulse.
REQ-032 start pulsed again at byte 3 of a frame -> frame unchanged, exactly one done, no second frame.
REQ-033 rst asserted during DATA of register 2 -> next cycle tx_valid=0, busy=0, regAddr=FIRST_REG, no done; subsequent start yields complete frame from header.
REQ-034 start in same cycle as done -> second frame header appears next cycle, back-to-back frames correct.
REQ-035 tx_ready held 0 for 100 cycles after header presented -> tx_data=A5, tx_valid=1 throughout; frame resumes intact when ready rises.

Source files
------------

// File: rtl/sm_regdump.sv
// ---------------------------------------------------------------------------
// sm_regdump
//
// Streams one framed dump of CPU debug registers over a valid/ready byte link.
// Each frame consists of one SYNC_BYTE header. Then, for every register index
// from FIRST_REG to LAST_REG, it sends one address byte {3'b000, index}
// followed by the 4 data bytes of that register, MSB first.
//
// Each register is read through the combinational debug port (regAddr ->
// regData) during a single capture cycle. The CPU keeps running, so a frame
// is not an atomic snapshot.
//
// Ports
//   clk       in   1   clock, all state on the rising edge
//   rst       in   1   synchronous active-high reset
//   start     in   1   single-cycle request for one frame (ignored while busy)
//   regAddr   out  5   debug register address (always the current index)
//   regData   in  32   debug register data, combinational from regAddr
//   tx_data   out  8   outgoing byte
//   tx_valid  out  1   tx_data holds a byte
//   tx_ready  in   1   sink accepts; transfer on tx_valid & tx_ready
//   busy      out  1   frame in progress
//   done      out  1   one-cycle pulse after the final transfer of a frame
// ---------------------------------------------------------------------------
module sm_regdump #(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [4:0]  regAddr,
   input  logic [31:0] regData,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);

   if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_param_check
      $error("sm_regdump: need FIRST_REG <= LAST_REG <= 31");
   end

   localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
   localparam logic [4:0] LastIdx  = 5'(LAST_REG);

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StCap,
      StAddr,
      StData
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  index_q, index_d;
   logic [31:0] shift_q, shift_d;
   logic [1:0]  cnt_q,   cnt_d;
   logic        done_q,  done_d;

   logic        xfer;

   // The outputs are decoded from state only. A stalled byte therefore holds
   // tx_data and tx_valid stable until it is accepted.
   assign xfer    = tx_valid & tx_ready;
   assign regAddr = index_q;
   assign done    = done_q;

   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      busy     = 1'b1;

      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) begin
               state_d = StHdr;
               index_d = FirstIdx;
            end
         end

         StHdr: begin
            tx_valid = 1'b1;
            tx_data  = SYNC_BYTE;
            if (xfer) begin
               state_d = StCap;
            end
         end

         // Single cycle in which regAddr has settled on the index.
         StCap: begin
            shift_d = regData;
            state_d = StAddr;
         end

         StAddr: begin
            tx_valid = 1'b1;
            tx_data  = {3'b000, index_q};
            if (xfer) begin
               state_d = StData;
               cnt_d   = 2'd0;
            end
         end

         StData: begin
            tx_valid = 1'b1;
            tx_data  = shift_q[31:24];
            if (xfer) begin
               shift_d = {shift_q[23:0], 8'h00};
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  // Compare before incrementing so LAST_REG=31 never wraps.
                  if (index_q == LastIdx) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     index_d = index_q + 5'd1;
                     state_d = StCap;
                  end
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         index_q <= FirstIdx;
         shift_q <= 32'h0;
         cnt_q   <= 2'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_sm_regdump.sv
// Directed bench for sm_regdump.
// dut0 uses the default parameters. dut1 dumps only register 5.
module tb_sm_regdump;

   logic        clk = 1'b0;
   logic        rst;

   logic        start0, tx_ready0;
   logic [4:0]  reg_addr0;
   logic [31:0] reg_data0;
   logic [7:0]  tx_data0;
   logic        tx_valid0, busy0, done0;

   logic        start1, tx_ready1;
   logic [4:0]  reg_addr1;
   logic [31:0] reg_data1;
   logic [7:0]  tx_data1;
   logic        tx_valid1, busy1, done1;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int         done0_cnt = 0;
   int         done1_cnt = 0;
   int         stab0_err = 0;
   int         stab1_err = 0;
   logic       pend0 = 1'b0, pend1 = 1'b0;
   logic [7:0] prev0 = 8'h00, prev1 = 8'h00;

   always #5 clk = ~clk;

   // CPU register model: PC at index 0, r_i = 0x1000_0000 + i.
   assign reg_data0 = (reg_addr0 == 5'd0) ? 32'h0000_0040 : 32'h1000_0000 + 32'(reg_addr0);
   assign reg_data1 = (reg_addr1 == 5'd5) ? 32'hDEAD_BEEF : 32'h0;

   sm_regdump dut0 (
      .clk      (clk),
      .rst      (rst),
      .start    (start0),
      .regAddr  (reg_addr0),
      .regData  (reg_data0),
      .tx_data  (tx_data0),
      .tx_valid (tx_valid0),
      .tx_ready (tx_ready0),
      .busy     (busy0),
      .done     (done0)
   );

   sm_regdump #(
      .FIRST_REG (5),
      .LAST_REG  (5),
      .SYNC_BYTE (8'hA5)
   ) dut1 (
      .clk      (clk),
      .rst      (rst),
      .start    (start1),
      .regAddr  (reg_addr1),
      .regData  (reg_data1),
      .tx_data  (tx_data1),
      .tx_valid (tx_valid1),
      .tx_ready (tx_ready1),
      .busy     (busy1),
      .done     (done1)
   );

   // Byte, done and stall-stability monitors on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_valid0 && tx_ready0) q0.push_back(tx_data0);
         if (tx_valid1 && tx_ready1) q1.push_back(tx_data1);
         if (done0) done0_cnt++;
         if (done1) done1_cnt++;
         if (pend0 && (!tx_valid0 || tx_data0 != prev0)) stab0_err++;
         if (pend1 && (!tx_valid1 || tx_data1 != prev1)) stab1_err++;
      end
      pend0 = !rst && tx_valid0 && !tx_ready0;
      pend1 = !rst && tx_valid1 && !tx_ready1;
      prev0 = tx_data0;
      prev1 = tx_data1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until done0 is high or the budget runs out; k is the ticks taken.
   task automatic wait_done0(input int budget, output int k);
      k = 0;
      while (!done0 && k < budget) begin
         tick();
         k++;
      end
   endtask

   function automatic logic [7:0] exp_byte0(input int n);
      int          m, i, b;
      logic [31:0] r;
      if (n == 0) return 8'hA5;
      m = n - 1;
      i = m / 5;
      b = m % 5;
      if (b == 0) return 8'(i);
      r = (i == 0) ? 32'h0000_0040 : 32'h1000_0000 + 32'(i);
      return 8'(r >> (8 * (4 - b)));
   endfunction

   task automatic compare_frame0(input string tag, input int offset);
      if (q0.size() >= offset + 161) begin
         for (int n = 0; n < 161; n++) begin
            check($sformatf("%s byte %0d", tag, n), 32'(q0[offset + n]), 32'(exp_byte0(n)));
         end
      end else begin
         check({tag, " short frame"}, q0.size(), offset + 161);
      end
   endtask

   initial begin
      int         k;
      int         hold_err;
      logic [7:0] exp1[6];

      rst       = 1'b1;
      start0    = 1'b0;
      start1    = 1'b0;
      tx_ready0 = 1'b1;
      tx_ready1 = 1'b1;

      // Reset, with start asserted to show that reset wins.
      start0 = 1'b1;
      tick();
      tick();
      start0 = 1'b0;
      rst    = 1'b0;
      check("rst tx_valid", tx_valid0, 0);
      check("rst tx_data", tx_data0, 0);
      check("rst busy", busy0, 0);
      check("rst done", done0, 0);
      check("rst regAddr0", reg_addr0, 0);
      check("rst regAddr1", reg_addr1, 5);
      tick();
      check("rst start ignored", busy0, 0);

      // Full default frame with ready held high.
      q0.delete();
      done0_cnt = 0;
      start0    = 1'b1;
      tick();
      start0 = 1'b0;
      check("hdr valid", tx_valid0, 1);
      check("hdr data", tx_data0, 8'hA5);
      check("hdr busy", busy0, 1);
      wait_done0(400, k);
      check("full done latency", k + 1, 194);
      check("full byte count", q0.size(), 161);
      compare_frame0("full", 0);
      tick();
      check("full done pulse width", done0, 0);
      check("full idle busy", busy0, 0);
      check("full done count", done0_cnt, 1);

      // Single register frame with ready toggling.
      q1.delete();
      done1_cnt = 0;
      stab1_err = 0;
      start1    = 1'b1;
      tick();
      start1 = 1'b0;
      k      = 0;
      while (!done1 && k < 100) begin
         tx_ready1 = ~tx_ready1;
         tick();
         k++;
      end
      tx_ready1 = 1'b1;
      check("r5 done seen", done1, 1);
      check("r5 byte count", q1.size(), 6);
      exp1 = '{8'hA5, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      if (q1.size() == 6) begin
         for (int n = 0; n < 6; n++) begin
            check($sformatf("r5 byte %0d", n), 32'(q1[n]), 32'(exp1[n]));
         end
      end
      tick();
      tick();
      check("r5 stability", stab1_err, 0);
      check("r5 done count", done1_cnt, 1);

      // Start while busy is ignored.
      q0.delete();
      done0_cnt = 0;
      start0    = 1'b1;
      tick();
      start0 = 1'b0;
      tick();
      tick();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done0(400, k);
      check("busy start done seen", done0, 1);
      repeat (20) tick();
      check("busy start byte count", q0.size(), 161);
      compare_frame0("busy start", 0);
      check("busy start done count", done0_cnt, 1);
      check("busy start idle", busy0, 0);

      // Reset during DATA of register 2.
      q0.delete();
      done0_cnt = 0;
      start0    = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (15) tick();
      check("abort in data", tx_data0, 8'h10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort tx_valid", tx_valid0, 0);
      check("abort busy", busy0, 0);
      check("abort regAddr", reg_addr0, 0);
      check("abort done", done0, 0);
      repeat (10) tick();
      check("abort no done", done0_cnt, 0);
      q0.delete();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done0(400, k);
      check("abort restart done", done0, 1);
      compare_frame0("abort restart", 0);

      // Start in the done cycle gives back-to-back frames.
      tick();
      q0.delete();
      done0_cnt = 0;
      start0    = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done0(400, k);
      check("b2b first done", done0, 1);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("b2b hdr valid", tx_valid0, 1);
      check("b2b hdr data", tx_data0, 8'hA5);
      wait_done0(400, k);
      check("b2b second done", done0, 1);
      check("b2b byte count", q0.size(), 322);
      compare_frame0("b2b f1", 0);
      compare_frame0("b2b f2", 161);
      tick();
      check("b2b done count", done0_cnt, 2);

      // Long stall on the header.
      q0.delete();
      stab0_err = 0;
      tx_ready0 = 1'b0;
      start0    = 1'b1;
      tick();
      start0   = 1'b0;
      hold_err = 0;
      repeat (100) begin
         if (!tx_valid0 || tx_data0 != 8'hA5) hold_err++;
         tick();
      end
      check("stall hold", hold_err, 0);
      check("stall no bytes", q0.size(), 0);
      tx_ready0 = 1'b1;
      wait_done0(400, k);
      check("stall done", done0, 1);
      compare_frame0("stall", 0);
      check("stall stability", stab0_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
